// File: rtl/fmul_round_stage_if.sv
// Upstream operand bundle and downstream FP32 result of the multiply back end, each with valid/ready.
// master drives operands and out_ready; slave is the round stage.
interface fmul_round_stage_if #(
   parameter int EXPW = 10
);
   logic            in_valid;
   logic            in_ready;
   logic            in_sign;
   logic [EXPW-1:0] in_exp;
   logic [47:0]     in_mant;
   logic            in_nan;
   logic            in_inf;
   logic            in_zero;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_result;
   logic [2:0]      out_flags;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fmul_round_stage.sv
// FP32 multiply back end: normalise, round-to-nearest-even, pack; denormals flush to zero.
// Latency 2 (normalise reg, round/pack reg); full-rate elastic pipe, in_ready combinational from out_ready.
module fmul_round_stage #(
   parameter int EXPW = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   fmul_round_stage_if.slave  bus
);
   typedef struct packed {
      logic              sign;
      logic              nan;
      logic              inf;
      logic              zero;
      logic signed [EXPW:0] e;
      logic [23:0]       m;
      logic              g;
      logic              s;
   } s1_t;

   localparam logic signed [EXPW:0] ONE  = 1;
   localparam logic signed [EXPW:0] ZERO = 0;
   localparam logic signed [EXPW:0] EMAX = 255;

   s1_t         s1_q, s1_d, norm;
   logic        s1_valid_q, s1_valid_d;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] result_q, result_d;
   logic [2:0]  flags_q, flags_d;

   logic        s1_adv;
   logic        in_ready;
   logic signed [EXPW:0] ext_exp;
   logic signed [EXPW:0] e2;
   logic        up;
   logic [24:0] r;
   logic [22:0] frac;
   logic        inexact;
   logic [31:0] res;
   logic [2:0]  flg;

   assign s1_adv   = !s2_valid_q || bus.out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign ext_exp  = {bus.in_exp[EXPW-1], bus.in_exp};

   // Stage 1: bring the product's leading one to bit 23 and split off guard/sticky.
   always_comb begin
      norm.sign = bus.in_sign;
      norm.nan  = bus.in_nan;
      norm.inf  = bus.in_inf;
      norm.zero = bus.in_zero;
      if (bus.in_mant[47]) begin
         norm.m = bus.in_mant[47:24];
         norm.g = bus.in_mant[23];
         norm.s = |bus.in_mant[22:0];
         norm.e = ext_exp + ONE;
      end else begin
         norm.m = bus.in_mant[46:23];
         norm.g = bus.in_mant[22];
         norm.s = |bus.in_mant[21:0];
         norm.e = ext_exp;
      end

      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      if (in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_d = norm;
         end
      end
   end

   // Stage 2: a rounding carry out of the mantissa leaves the fraction zero and bumps the exponent.
   always_comb begin
      up      = s1_q.g && (s1_q.s || s1_q.m[0]);
      r       = {1'b0, s1_q.m} + {24'd0, up};
      e2      = r[24] ? (s1_q.e + ONE) : s1_q.e;
      frac    = r[24] ? r[23:1] : r[22:0];
      inexact = s1_q.g || s1_q.s;

      if (s1_q.nan) begin
         res = 32'h7FC0_0000;
         flg = 3'b000;
      end else if (s1_q.inf) begin
         res = {s1_q.sign, 8'hFF, 23'h0};
         flg = 3'b000;
      end else if (s1_q.zero) begin
         res = {s1_q.sign, 31'h0};
         flg = 3'b000;
      end else if (e2 >= EMAX) begin
         res = {s1_q.sign, 8'hFF, 23'h0};
         flg = 3'b101;
      end else if (e2 <= ZERO) begin
         res = {s1_q.sign, 31'h0};
         flg = 3'b011;
      end else begin
         res = {s1_q.sign, e2[7:0], frac};
         flg = {2'b00, inexact};
      end

      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      flags_d    = flags_q;
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = res;
            flags_d  = flg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = s2_valid_q;
   assign bus.out_result = result_q;
   assign bus.out_flags  = flags_q;
endmodule

// File: tb/tb_fmul_round_stage.sv
// Directed vectors with hand-computed FP32 results, scoreboarded in acceptance order.
module tb_fmul_round_stage;
   localparam int NV = 15;

   typedef struct {
      logic              sign;
      logic              nan;
      logic              inf;
      logic              zero;
      logic signed [9:0] exp;
      logic [47:0]       mant;
      logic [31:0]       res;
      logic [2:0]        flg;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic [2:0]  flg;
   } exp_t;

   logic  clk;
   logic  rst_n;
   int    total;
   int    bad;
   vec_t  vecs [NV];
   exp_t  q [$];
   logic [31:0] held;

   fmul_round_stage_if #(.EXPW(10)) bus ();

   fmul_round_stage #(.EXPW(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   task automatic setv(input int i, input logic sg, input logic nn, input logic nf, input logic zr,
                       input logic signed [9:0] ex, input logic [47:0] mt,
                       input logic [31:0] rs, input logic [2:0] fl);
      vecs[i].sign = sg;
      vecs[i].nan  = nn;
      vecs[i].inf  = nf;
      vecs[i].zero = zr;
      vecs[i].exp  = ex;
      vecs[i].mant = mt;
      vecs[i].res  = rs;
      vecs[i].flg  = fl;
   endtask

   // Call at #1 after a rising edge; returns at #1 after the accepting edge.
   task automatic send(input int i);
      logic ok;
      exp_t e;
      bus.in_sign  = vecs[i].sign;
      bus.in_nan   = vecs[i].nan;
      bus.in_inf   = vecs[i].inf;
      bus.in_zero  = vecs[i].zero;
      bus.in_exp   = vecs[i].exp;
      bus.in_mant  = vecs[i].mant;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      chk($sformatf("accept_%0d", i), {31'd0, ok}, 32'd1);
      if (ok) begin
         e.idx = i;
         e.res = vecs[i].res;
         e.flg = vecs[i].flg;
         q.push_back(e);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int c = 0; c < 60; c++) begin
         if (q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk(tag, q.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         chk("out_expected", {31'd0, q.size() != 0}, 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("res_%0d", e.idx), bus.out_result, e.res);
            chk($sformatf("flg_%0d", e.idx), {29'd0, bus.out_flags}, {29'd0, e.flg});
         end
      end
   end

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      total = 0;
      bad   = 0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_nan    = 1'b0;
      bus.in_inf    = 1'b0;
      bus.in_zero   = 1'b0;
      bus.in_exp    = '0;
      bus.in_mant   = '0;
      bus.out_ready = 1'b1;

      setv(0,  0, 0, 0, 0, 10'sd127, 48'h9000_0000_0000, 32'h4010_0000, 3'b000);
      setv(1,  0, 0, 0, 0, 10'sd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001);
      setv(2,  0, 0, 0, 0, 10'sd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001);
      setv(3,  0, 0, 0, 0, 10'sd127, 48'h7FFF_FFFF_FFFF, 32'h4000_0000, 3'b001);
      setv(4,  0, 0, 0, 0, 10'sd254, 48'h8000_0000_0000, 32'h7F80_0000, 3'b101);
      setv(5,  1, 0, 0, 0, 10'sd0,   48'h4000_0000_0000, 32'h8000_0000, 3'b011);
      setv(6,  1, 1, 1, 0, 10'sd127, 48'h9000_0000_0000, 32'h7FC0_0000, 3'b000);
      setv(7,  1, 0, 1, 0, 10'sd12,  48'h4000_0000_0000, 32'hFF80_0000, 3'b000);
      setv(8,  1, 0, 0, 1, 10'sd130, 48'h8000_0000_0000, 32'h8000_0000, 3'b000);
      setv(9,  0, 0, 0, 0, -10'sd5,  48'h8000_0000_0000, 32'h0000_0000, 3'b011);
      setv(10, 1, 0, 0, 0, 10'sd200, 48'h4000_0000_0000, 32'hE400_0000, 3'b000);
      setv(11, 0, 0, 0, 0, 10'sd127, 48'h4000_0060_0000, 32'h3F80_0001, 3'b001);
      setv(12, 0, 0, 0, 0, 10'sd253, 48'hFFFF_FFFF_FFFF, 32'h7F80_0000, 3'b101);
      setv(13, 0, 0, 0, 0, 10'sd1,   48'h4000_0000_0000, 32'h0080_0000, 3'b000);
      setv(14, 0, 0, 0, 0, 10'sd254, 48'h4000_0000_0000, 32'h7F00_0000, 3'b000);

      #3;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_result", bus.out_result, 32'd0);
      chk("rst_flags", {29'd0, bus.out_flags}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: the accepting edge is edge 1, out_valid appears after edge 2.
      send(0);
      chk("lat_edge1", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_edge2", {31'd0, bus.out_valid}, 32'd1);
      drain("drain_lat");

      for (int i = 1; i < NV; i++) send(i);
      drain("drain_dir");

      bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(i);
         end
         begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            held = bus.out_result;
            for (int c = 0; c < 2; c++) begin
               @(posedge clk);
               #1;
               chk("bp_valid_hold", {31'd0, bus.out_valid}, 32'd1);
               chk("bp_result_hold", bus.out_result, held);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain("drain_bp");
      @(posedge clk);
      #1;
      chk("bp_idle", {31'd0, bus.out_valid}, 32'd0);

      bus.out_ready = 1'b0;
      send(0);
      send(4);
      chk("mid_full", {31'd0, bus.out_valid && !bus.in_ready}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_result", bus.out_result, 32'd0);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      send(11);
      drain("drain_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
